// File: rtl/band_meter_pkg.sv
// Shared definitions for the band meter mixer: combine-mode encodings,
// the frame sequencer state type and width helpers.
package band_meter_pkg;

    localparam logic [1:0] MODE_MAX = 2'd0;
    localparam logic [1:0] MODE_AVG = 2'd1;
    localparam logic [1:0] MODE_SEL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Width of the cross-channel sum that cannot overflow.
    function automatic int sum_width(input int lvl_w, input int num_ch);
        return lvl_w + $clog2(num_ch);
    endfunction

    // Index width for a set of n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/band_peak_hold.sv
// Serial peak-hold engine: one band's peak and hold counter are updated per
// enabled cycle, selected by idx. Built only when BAND_METER_PEAK_EN is defined.
module band_peak_hold
    import band_meter_pkg::*;
#(
    parameter int NUM_BANDS   = 7,
    parameter int LVL_W       = 8,
    parameter int HOLD_FRAMES = 16,
    parameter int DECAY_STEP  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            en,
    input  logic [sel_width(NUM_BANDS)-1:0] idx,
    input  logic [LVL_W-1:0]                lvl,
    output logic [NUM_BANDS*LVL_W-1:0]      peaks
);

    localparam int                HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_L = HOLD_W'(HOLD_FRAMES);
    localparam logic [LVL_W-1:0]  DEC_L  = LVL_W'(DECAY_STEP);

    logic [LVL_W-1:0]  p_r [NUM_BANDS];
    logic [HOLD_W-1:0] h_r [NUM_BANDS];

    logic [LVL_W-1:0]  p_cur_s;
    logic [LVL_W-1:0]  p_dec_s;
    logic [LVL_W-1:0]  p_nxt_s;
    logic [HOLD_W-1:0] h_cur_s;
    logic [HOLD_W-1:0] h_nxt_s;

    // Next peak/hold for the indexed band: capture, hold, then saturating decay.
    always_comb begin
        p_cur_s = p_r[idx];
        h_cur_s = h_r[idx];
        p_nxt_s = p_cur_s;
        h_nxt_s = h_cur_s;
        if (p_cur_s > DEC_L) begin
            p_dec_s = p_cur_s - DEC_L;
        end else begin
            p_dec_s = '0;
        end
        if (lvl >= p_cur_s) begin
            p_nxt_s = lvl;
            h_nxt_s = HOLD_L;
        end else if (h_cur_s != '0) begin
            h_nxt_s = h_cur_s - HOLD_W'(1);
        end else if (lvl > p_dec_s) begin
            p_nxt_s = lvl;
        end else begin
            p_nxt_s = p_dec_s;
        end
    end

    // Peak and hold storage, written only for the band being processed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                p_r[b] <= '0;
                h_r[b] <= '0;
            end
        end else if (en) begin
            p_r[idx] <= p_nxt_s;
            h_r[idx] <= h_nxt_s;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_flat
        assign peaks[b*LVL_W +: LVL_W] = p_r[b];
    end

endmodule

// File: rtl/band_meter_mixer.sv
// Cross-channel band level combiner with frame-atomic output commit.
// Peak-hold is built when BAND_METER_PEAK_EN is defined; otherwise peak mirrors level.
module band_meter_mixer
    import band_meter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int NUM_BANDS   = 7,
    parameter int LVL_W       = 8,
    parameter int HOLD_FRAMES = 16,
    parameter int DECAY_STEP  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              ready,
    input  logic [NUM_CH*NUM_BANDS*LVL_W-1:0] band_in,
    input  logic [1:0]                        mode,
    input  logic [sel_width(NUM_CH)-1:0]      ch_sel,
    output logic [NUM_BANDS*LVL_W-1:0]        level,
    output logic [NUM_BANDS*LVL_W-1:0]        peak,
    output logic                              valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int                SEL_W    = sel_width(NUM_CH);
    localparam int                IDX_W    = sel_width(NUM_BANDS);
    localparam int                SUM_W    = sum_width(LVL_W, NUM_CH);
    localparam int                SHIFT    = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANDS - 1);
    localparam logic [SEL_W:0]    NUM_CH_L = (SEL_W + 1)'(NUM_CH);

    if ((NUM_CH < 1) || ((NUM_CH & (NUM_CH - 1)) != 0) || (NUM_BANDS < 1) ||
        (HOLD_FRAMES < 1) || (DECAY_STEP < 0)) begin : g_param_check
        $error("band_meter_mixer: illegal parameter set");
    end

    state_t                            state_r;
    state_t                            state_s;
    logic [NUM_CH*NUM_BANDS*LVL_W-1:0] cap_band_r;
    logic [1:0]                        cap_mode_r;
    logic [SEL_W-1:0]                  cap_sel_r;
    logic [IDX_W-1:0]                  band_idx_r;
    logic [LVL_W-1:0]                  work_lvl_r [NUM_BANDS];

    logic [LVL_W-1:0]                  ch_val_s [NUM_CH];
    logic [LVL_W-1:0]                  max_s;
    logic [LVL_W-1:0]                  avg_s;
    logic [LVL_W-1:0]                  sel_val_s;
    logic [LVL_W-1:0]                  comb_s;
    logic [SUM_W-1:0]                  sum_s;
    logic [NUM_BANDS*LVL_W-1:0]        work_flat_s;
    logic [NUM_BANDS*LVL_W-1:0]        peak_src_s;
    logic                              run_s;

    // Combine the channels of the current band according to the captured mode.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_val_s[c] = cap_band_r[(c*NUM_BANDS + int'(band_idx_r))*LVL_W +: LVL_W];
        end
        max_s = ch_val_s[0];
        sum_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_val_s[c] > max_s) begin
                max_s = ch_val_s[c];
            end else begin
                max_s = max_s;
            end
            sum_s = sum_s + SUM_W'(ch_val_s[c]);
        end
        avg_s = LVL_W'(sum_s >> SHIFT);
        if ({1'b0, cap_sel_r} < NUM_CH_L) begin
            sel_val_s = ch_val_s[cap_sel_r];
        end else begin
            sel_val_s = ch_val_s[0];
        end
        case (cap_mode_r)
            MODE_MAX: comb_s = max_s;
            MODE_AVG: comb_s = avg_s;
            MODE_SEL: comb_s = sel_val_s;
            default:  comb_s = max_s;
        endcase
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_work_flat
        assign work_flat_s[b*LVL_W +: LVL_W] = work_lvl_r[b];
    end

    assign run_s = (state_r == ST_RUN);

`ifdef BAND_METER_PEAK_EN
    band_peak_hold #(
        .NUM_BANDS   (NUM_BANDS),
        .LVL_W       (LVL_W),
        .HOLD_FRAMES (HOLD_FRAMES),
        .DECAY_STEP  (DECAY_STEP)
    ) u_peak_hold (
        .clock (clock),
        .reset (reset),
        .en    (run_s),
        .idx   (band_idx_r),
        .lvl   (comb_s),
        .peaks (peak_src_s)
    );
`else
    assign peak_src_s = work_flat_s;
`endif

    // Frame sequencer next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ready) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (band_idx_r == LAST_IDX) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Frame sequencer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture, per-band working registers and the atomic output commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_band_r <= '0;
            cap_mode_r <= MODE_MAX;
            cap_sel_r  <= '0;
            band_idx_r <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                work_lvl_r[b] <= '0;
            end
            level   <= '0;
            peak    <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= (state_r == ST_COMMIT);
            busy    <= (state_s != ST_IDLE);
            // A strobe during COMMIT is also dropped: only IDLE accepts a frame.
            overrun <= overrun | (ready & (state_r != ST_IDLE));
            case (state_r)
                ST_IDLE: begin
                    if (ready) begin
                        cap_band_r <= band_in;
                        cap_mode_r <= mode;
                        cap_sel_r  <= ch_sel;
                        band_idx_r <= '0;
                    end
                end
                ST_RUN: begin
                    work_lvl_r[band_idx_r] <= comb_s;
                    if (band_idx_r != LAST_IDX) begin
                        band_idx_r <= band_idx_r + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    level <= work_flat_s;
                    peak  <= peak_src_s;
                end
                default: ;
            endcase
        end
    end

endmodule
